// File: rtl/bullet_pkg.sv
// Shared definitions for the player bullet pool and its neighbours.
//   COORD_W       : screen coordinate width
//   NUM_SLOTS_DEF : default number of concurrent player bullets
//   V_TOP_DEF     : default top-of-screen retire line
//   slot_state_t  : per-slot state (IDLE = free, FLY = in flight)
package bullet_pkg;

    localparam int COORD_W       = 10;
    localparam int NUM_SLOTS_DEF = 4;
    localparam int V_TOP_DEF     = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/bullet_scheduler_if.sv
// Bundle between the bullet scheduler and its neighbours.
//   h_my_plane/v_my_plane : plane position used as the launch point
//   fire                  : fire key level
//   hit                   : per-slot collision strobe
//   h_bullet/v_bullet     : slot i coordinates at bits [10i+9:10i]
//   active                : slot in flight
//   fired/dropped         : one-cycle launch / rejected-press pulses
//   full                  : every slot in flight
// master = upstream/downstream logic, slave = the scheduler.
interface bullet_scheduler_if
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF
);
    logic [COORD_W-1:0]           h_my_plane;
    logic [COORD_W-1:0]           v_my_plane;
    logic                         fire;
    logic [NUM_SLOTS-1:0]         hit;
    logic [COORD_W*NUM_SLOTS-1:0] h_bullet;
    logic [COORD_W*NUM_SLOTS-1:0] v_bullet;
    logic [NUM_SLOTS-1:0]         active;
    logic                         fired;
    logic                         dropped;
    logic                         full;

    modport master (
        output h_my_plane, v_my_plane, fire, hit,
        input  h_bullet, v_bullet, active, fired, dropped, full
    );

    modport slave (
        input  h_my_plane, v_my_plane, fire, hit,
        output h_bullet, v_bullet, active, fired, dropped, full
    );
endinterface

// File: rtl/move_tick_gen.sv
// Free-running divider producing a one-cycle move tick every MOVE_DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count restarts at 0)
//   tick  : high for the single cycle where the count is MOVE_DIV-1
module move_tick_gen #(
    parameter int MOVE_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(MOVE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/bullet_scheduler.sv
// Player bullet pool: turns fire presses into launches into the lowest free
// slot, enforces a launch cooldown counted in move ticks, moves in-flight
// bullets up by STEP each tick and retires them at the top or on a hit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bullet_scheduler_if (plane, fire, hit in;
//                bullet coordinates, active, fired, dropped, full out)
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int MOVE_DIV  = 100000,
    parameter int STEP      = 1,
    parameter int V_TOP     = V_TOP_DEF,
    parameter int COOLDOWN  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bullet_scheduler_if.slave  bus
);
    localparam int                 CD_W    = $clog2(COOLDOWN + 2);
    localparam logic [COORD_W:0]   RET_LIM = (COORD_W + 1)'(V_TOP + STEP);
    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
    localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN);

    logic                              tick;
    logic                              fire_d;
    logic                              fire_rise;
    logic [CD_W-1:0]                   cd_q;
    slot_state_t [NUM_SLOTS-1:0]       st_q, st_d;
    logic [NUM_SLOTS-1:0][COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [NUM_SLOTS-1:0]              active;
    logic [NUM_SLOTS-1:0]              launch_sel;
    logic                              found;
    logic                              launch;
    logic                              fired_q, dropped_q;

    move_tick_gen #(.MOVE_DIV(MOVE_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign fire_rise = bus.fire & ~fire_d;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) active[i] = (st_q[i] == FLY);
    end

    // Lowest-index free slot, judged on the registered state: a slot that
    // retires this cycle is still counted busy.
    always_comb begin
        launch_sel = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active[i] && !found) begin
                launch_sel[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign launch = fire_rise && (cd_q == '0) && found;

    // Slot next-state: hit beats the tick retire, which beats the move.
    // Only IDLE slots can be launched, so a new bullet never moves on its
    // launch cycle.
    always_comb begin
        st_d = st_q;
        h_d  = h_q;
        v_d  = v_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (st_q[i] == FLY) begin
                if (bus.hit[i] || (tick && ({1'b0, v_q[i]} < RET_LIM))) begin
                    st_d[i] = IDLE;
                    h_d[i]  = '0;
                    v_d[i]  = '0;
                end else if (tick) begin
                    v_d[i] = v_q[i] - STEP_C;
                end
            end else if (launch && launch_sel[i]) begin
                st_d[i] = FLY;
                h_d[i]  = bus.h_my_plane;
                v_d[i]  = bus.v_my_plane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) st_q[i] <= IDLE;
            h_q       <= '0;
            v_q       <= '0;
            fire_d    <= 1'b0;
            cd_q      <= '0;
            fired_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fire_d    <= bus.fire;
            fired_q   <= launch;
            dropped_q <= fire_rise && !launch;
            // A fresh load wins over a same-cycle tick decrement.
            if (launch)                 cd_q <= CD_LOAD;
            else if (tick && cd_q != '0) cd_q <= cd_q - CD_W'(1);
        end
    end

    assign bus.h_bullet = h_q;
    assign bus.v_bullet = v_q;
    assign bus.active   = active;
    assign bus.fired    = fired_q;
    assign bus.dropped  = dropped_q;
    assign bus.full     = &active;
endmodule

// File: tb/tb_bullet_scheduler.sv
module tb_bullet_scheduler;
    localparam int NS       = 4;
    localparam int MOVE_DIV = 4;
    localparam int STEP     = 1;
    localparam int V_TOP    = 1;
    localparam int COOLDOWN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bullet_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    bullet_scheduler #(
        .NUM_SLOTS (NS),
        .MOVE_DIV  (MOVE_DIV),
        .STEP      (STEP),
        .V_TOP     (V_TOP),
        .COOLDOWN  (COOLDOWN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: pool of bullets as plain integers.
    int m_act [NS];
    int m_h   [NS];
    int m_v   [NS];
    int m_cd, m_div;
    bit m_fired, m_dropped, m_fire_d;

    always @(posedge clk or negedge rst_n) begin : model
        bit tk, rise, go;
        int idx;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_h[i] = 0; m_v[i] = 0; end
            m_cd = 0; m_div = 0; m_fired = 0; m_dropped = 0; m_fire_d = 0;
        end else begin
            tk   = (m_div == MOVE_DIV - 1);
            rise = bus.fire && !m_fire_d;
            idx  = -1;
            for (int i = NS - 1; i >= 0; i--) if (m_act[i] == 0) idx = i;
            go = rise && (m_cd == 0) && (idx >= 0);
            for (int i = 0; i < NS; i++) begin
                if (m_act[i] != 0) begin
                    if (bus.hit[i] || (tk && m_v[i] < V_TOP + STEP)) begin
                        m_act[i] = 0; m_h[i] = 0; m_v[i] = 0;
                    end else if (tk) begin
                        m_v[i] = m_v[i] - STEP;
                    end
                end
            end
            if (go) begin
                m_act[idx] = 1;
                m_h[idx]   = int'(bus.h_my_plane);
                m_v[idx]   = int'(bus.v_my_plane);
            end
            m_fired   = go;
            m_dropped = rise && !go;
            if (go)                  m_cd = COOLDOWN;
            else if (tk && m_cd > 0) m_cd = m_cd - 1;
            m_div    = (m_div + 1) % MOVE_DIV;
            m_fire_d = bus.fire;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        int full_e;
        full_e = 1;
        for (int i = 0; i < NS; i++) begin
            check($sformatf("model active[%0d]", i), 64'(bus.active[i]), 64'(m_act[i]));
            check($sformatf("model h[%0d]", i), 64'(bus.h_bullet[10*i +: 10]), 64'(m_h[i]));
            check($sformatf("model v[%0d]", i), 64'(bus.v_bullet[10*i +: 10]), 64'(m_v[i]));
            if (m_act[i] == 0) full_e = 0;
        end
        check("model fired", 64'(bus.fired), 64'(m_fired));
        check("model dropped", 64'(bus.dropped), 64'(m_dropped));
        check("model full", 64'(bus.full), 64'(full_e));
    endtask

    // Advance n clocks; outputs compared against the model 1 time unit after
    // every rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic step_nochk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [9:0] h_of(input int i);
        return bus.h_bullet[10*i +: 10];
    endfunction

    function automatic logic [9:0] v_of(input int i);
        return bus.v_bullet[10*i +: 10];
    endfunction

    initial begin
        int guard;
        bus.fire = 0; bus.hit = '0; bus.h_my_plane = '0; bus.v_my_plane = '0;
        step_nochk(3);
        rst_n = 1'b1;
        check("reset active", 64'(bus.active), 64'd0);
        check("reset h", 64'(bus.h_bullet), 64'd0);
        check("reset fired", 64'(bus.fired), 64'd0);

        // Basic launch and flight, fire held for 100 cycles.
        bus.h_my_plane = 10'd320; bus.v_my_plane = 10'd400; bus.fire = 1;
        step(1);
        check("launch active", 64'(bus.active), 64'b0001);
        check("launch h0", 64'(h_of(0)), 64'd320);
        check("launch v0", 64'(v_of(0)), 64'd400);
        check("launch fired", 64'(bus.fired), 64'd1);
        step(1);
        check("fired one cycle", 64'(bus.fired), 64'd0);
        step(11);
        check("v after 3 ticks", 64'(v_of(0)), 64'd397);
        step(88);
        check("held fire one launch", 64'(bus.active), 64'b0001);
        check("v after 25 ticks", 64'(v_of(0)), 64'd375);
        bus.fire = 0;
        step(1);

        // Cooldown.
        bus.h_my_plane = 10'd200; bus.v_my_plane = 10'd300; bus.fire = 1;
        step(1);
        check("cd launch slot1", 64'(bus.active), 64'b0011);
        bus.fire = 0; step(2); bus.fire = 1; step(1);
        check("cd dropped", 64'(bus.dropped), 64'd1);
        bus.fire = 0; step(10);
        bus.h_my_plane = 10'd210; bus.v_my_plane = 10'd310; bus.fire = 1;
        step(1);
        check("cd expired launch", 64'(bus.active), 64'b0111);
        check("slot2 h", 64'(h_of(2)), 64'd210);
        bus.fire = 0; step(10);

        // Full pool, reject, hit frees a slot.
        bus.h_my_plane = 10'd230; bus.v_my_plane = 10'd330; bus.fire = 1;
        step(1);
        check("full set", 64'(bus.full), 64'd1);
        bus.fire = 0; step(10); bus.fire = 1; step(1);
        check("full dropped", 64'(bus.dropped), 64'd1);
        check("full no launch", 64'(bus.active), 64'b1111);
        bus.fire = 0; bus.hit = 4'b0100;
        step(1);
        check("hit retire", 64'(bus.active), 64'b1011);
        check("hit clears h2", 64'(h_of(2)), 64'd0);
        step(1);                      // hit on idle slot is ignored
        bus.hit = '0; step(8);
        bus.h_my_plane = 10'd100; bus.v_my_plane = 10'd200; bus.fire = 1;
        step(1);
        check("refill slot2", 64'(bus.active), 64'b1111);
        check("refill h2", 64'(h_of(2)), 64'd100);
        bus.fire = 0; step(10);

        // Hit coinciding with tick, then launch alongside a retire.
        guard = 0;
        while (m_div != MOVE_DIV - 1 && guard < 2 * MOVE_DIV) begin step(1); guard++; end
        check("tick align", 64'(m_div), 64'(MOVE_DIV - 1));
        bus.hit = 4'b0001;
        step(1);
        check("hit+tick retire", 64'(bus.active), 64'b1110);
        check("hit+tick v0", 64'(v_of(0)), 64'd0);
        bus.hit = '0; step(10);
        bus.h_my_plane = 10'd60; bus.v_my_plane = 10'd250; bus.fire = 1; bus.hit = 4'b0010;
        step(1);
        check("launch+retire", 64'(bus.active), 64'b1101);
        check("launch+retire h0", 64'(h_of(0)), 64'd60);
        bus.fire = 0; bus.hit = '0; step(10);

        // Asynchronous reset mid-flight, then top-of-screen retire.
        #2;
        rst_n = 1'b0;
        #1;
        check("async active", 64'(bus.active), 64'd0);
        check("async h", 64'(bus.h_bullet), 64'd0);
        check("async v", 64'(bus.v_bullet), 64'd0);
        step_nochk(2);
        rst_n = 1'b1;
        bus.h_my_plane = 10'd50; bus.v_my_plane = 10'd3; bus.fire = 1;
        step(1);
        check("top launch v0", 64'(v_of(0)), 64'd3);
        bus.fire = 0;
        step(2);
        check("no tick before 4th edge", 64'(v_of(0)), 64'd3);
        step(1);
        check("first tick 4th edge", 64'(v_of(0)), 64'd2);
        step(4);
        check("v at 1", 64'(v_of(0)), 64'd1);
        step(4);
        check("top retire active", 64'(bus.active), 64'd0);
        check("top retire v0", 64'(v_of(0)), 64'd0);
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
